// File: rtl/usb_rst_pkg.sv
// usb_rst_pkg: shared types and register map for the USB chip reset sequencer
package usb_rst_pkg;
    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        SETTLE = 2'd1,
        READY  = 2'd2
    } state_e;

    localparam logic [1:0] REG_STATUS    = 2'd0;
    localparam logic [1:0] REG_IRQ_EN    = 2'd1;
    localparam logic [1:0] REG_RST_COUNT = 2'd2;

    localparam int STATUS_READY = 0;
    localparam int STATUS_BUSY  = 1;
    localparam int STATUS_IRQ   = 2;
endpackage

// File: rtl/usb_rst_sequencer_sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    // two-stage capture, cleared by the async reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/usb_rst_sequencer.sv
// usb_rst_sequencer: timed USB chip reset with settle delay, status slave and irq
module usb_rst_sequencer
    import usb_rst_pkg::*;
#(
    parameter int ASSERT_CYCLES = 500,
    parameter int SETTLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rst_req,
    output logic        usb_rst_n,
    output logic        ready,
    output logic        irq,
    input  logic        chipselect,
    input  logic [1:0]  address,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata
);
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic             req_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             usb_rst_n_q, usb_rst_n_d;
    logic             ready_q, ready_d;
    logic             pend_q, pend_d;
    logic             en_q, en_d;
    logic [15:0]      rcnt_q, rcnt_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             released;
    logic             settled;
    logic             wr, rd;
    logic [31:0]      status;
    logic             unused_wdata;

    sync_2ff #(.W(1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (rst_req),
        .q_o     (req_s)
    );

    // sequencer: hold reset for the minimum width, then wait out the settle time
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        released = 1'b0;
        settled  = 1'b0;
        case (state_q)
            ASSERT: begin
                if (cnt_q == A_LAST && !req_s) begin
                    state_d  = SETTLE;
                    cnt_d    = '0;
                    released = 1'b1;
                end else begin
                    cnt_d = (cnt_q == A_LAST) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (req_s) begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                end else if (cnt_q == S_LAST) begin
                    state_d = READY;
                    cnt_d   = '0;
                    settled = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            READY: begin
                if (req_s) begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ASSERT;
                cnt_d   = '0;
            end
        endcase
        usb_rst_n_d = state_d != ASSERT;
        ready_d     = state_d == READY;
    end

    // register file: status, irq enable, completed-reset counter, registered read data
    always_comb begin
        wr                   = chipselect && !write_n;
        rd                   = chipselect && !read_n;
        status               = '0;
        status[STATUS_READY] = ready_q;
        status[STATUS_BUSY]  = state_q != READY;
        status[STATUS_IRQ]   = pend_q;
        pend_d = settled || (pend_q && !(wr && address == REG_STATUS && writedata[STATUS_IRQ]));
        en_d   = (wr && address == REG_IRQ_EN) ? writedata[0] : en_q;
        rcnt_d = released ? rcnt_q + 16'd1 : rcnt_q;
        readdata_d = !rd                       ? readdata_q :
                     address == REG_STATUS    ? status :
                     address == REG_IRQ_EN    ? {31'd0, en_q} :
                     address == REG_RST_COUNT ? {16'd0, rcnt_q} : 32'd0;
    end

    // state and register updates; async reset starts a fresh power-on sequence
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ASSERT;
            cnt_q       <= '0;
            usb_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            pend_q      <= 1'b0;
            en_q        <= 1'b0;
            rcnt_q      <= '0;
            readdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            usb_rst_n_q <= usb_rst_n_d;
            ready_q     <= ready_d;
            pend_q      <= pend_d;
            en_q        <= en_d;
            rcnt_q      <= rcnt_d;
            readdata_q  <= readdata_d;
        end
    end

    assign unused_wdata = ^{writedata[31:3], writedata[1]};
    assign usb_rst_n    = usb_rst_n_q;
    assign ready        = ready_q;
    assign irq          = pend_q && en_q;
    assign readdata     = readdata_q;
endmodule
